// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-port (I-cache / D-cache) memory arbiter:
//   - arbiter FSM state encoding
//   - requester port identifiers (PORT_I = 0, PORT_D = 1)
//   - memory operation encoding
//   - default line and address widths
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  // Default width of one memory line, in bits.
  localparam int CACHE_LINE_SIZE_DEF = 128;

  // Default address width, in bits.
  localparam int ADDR_W_DEF = 32;

  // Requester identifiers; also the encoding of out_grant_dcache.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Memory operation latched at grant time.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arb_rr.sv
// -----------------------------------------------------------------------------
// mem_arb_rr
// Combinational two-way round-robin pick between the I-cache and D-cache.
// When only one port requests, that port wins. When both request, the port
// that was NOT granted last wins.
//
// Ports:
//   icache_req_i  - I-cache is requesting
//   dcache_req_i  - D-cache is requesting
//   last_grant_i  - port served by the most recent completed transaction
//   winner_o      - selected port (PORT_I / PORT_D); only meaningful when at
//                   least one request is present
// -----------------------------------------------------------------------------
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic icache_req_i,
  input  logic dcache_req_i,
  input  logic last_grant_i,
  output logic winner_o
);

  always_comb begin
    winner_o = PORT_I;
    if (icache_req_i && dcache_req_i) begin
      // Tie: hand the line to whoever did not have it last time.
      winner_o = (last_grant_i == PORT_I) ? PORT_D : PORT_I;
    end else if (dcache_req_i) begin
      winner_o = PORT_D;
    end else begin
      winner_o = PORT_I;
    end
  end

endmodule : mem_arb_rr

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a single line-wide memory port between an I-cache (read only)
// and a D-cache (refill reads and writeback writes).
//
// One transaction at a time: IDLE samples requests and grants one port,
// BUSY holds the memory command until in_mem_ready, RESP pulses the owner's
// ready for one cycle and then returns to IDLE.
//
// Ports:
//   clk, reset                      - clock, asynchronous active-high reset
//   in_icache_mem_read_en/addr      - I-cache line-fill request (held to ready)
//   out_icache_mem_ready/read_data  - I-cache completion pulse and fill data
//   in_dcache_mem_read_en/write_en  - D-cache refill / writeback request
//   in_dcache_mem_addr/write_data   - D-cache line address and writeback line
//   out_dcache_mem_ready/read_data  - D-cache completion pulse and refill data
//   out_mem_read_en/write_en        - memory command, held until in_mem_ready
//   out_mem_addr/write_data         - memory address and write line
//   in_mem_ready/read_data          - memory completion and read line
//   out_grant_dcache                - owner of current/last transaction (1 = D)
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int CACHE_LINE_SIZE = CACHE_LINE_SIZE_DEF,
  parameter int ADDR_W          = ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,

  // I-cache port
  input  logic                       in_icache_mem_read_en,
  input  logic [ADDR_W-1:0]          in_icache_mem_addr,
  output logic                       out_icache_mem_ready,
  output logic [CACHE_LINE_SIZE-1:0] out_icache_mem_read_data,

  // D-cache port
  input  logic                       in_dcache_mem_read_en,
  input  logic                       in_dcache_mem_write_en,
  input  logic [ADDR_W-1:0]          in_dcache_mem_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_dcache_mem_write_data,
  output logic                       out_dcache_mem_ready,
  output logic [CACHE_LINE_SIZE-1:0] out_dcache_mem_read_data,

  // Memory port
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  output logic [ADDR_W-1:0]          out_mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
  input  logic                       in_mem_ready,
  input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,

  // Grant status
  output logic                       out_grant_dcache
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e                 state_q,      state_d;
  logic                       owner_q,      owner_d;
  mem_op_e                    op_q,         op_d;
  logic [ADDR_W-1:0]          addr_q,       addr_d;
  logic [CACHE_LINE_SIZE-1:0] wdata_q,      wdata_d;
  logic                       last_grant_q, last_grant_d;
  logic [CACHE_LINE_SIZE-1:0] irdata_q,     irdata_d;
  logic [CACHE_LINE_SIZE-1:0] drdata_q,     drdata_d;

  // ---------------------------------------------------------------------------
  // Request decode and round-robin pick
  // ---------------------------------------------------------------------------
  logic icache_req;
  logic dcache_req;
  logic any_req;
  logic winner;

  assign icache_req = in_icache_mem_read_en;
  assign dcache_req = in_dcache_mem_read_en | in_dcache_mem_write_en;
  assign any_req    = icache_req | dcache_req;

  mem_arb_rr u_rr (
    .icache_req_i (icache_req),
    .dcache_req_i (dcache_req),
    .last_grant_i (last_grant_q),
    .winner_o     (winner)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    irdata_d     = irdata_q;
    drdata_d     = drdata_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = winner;
          state_d = BUSY;
          if (winner == PORT_D) begin
            // A D-cache asserting both enables is treated as a writeback.
            op_d   = in_dcache_mem_write_en ? OP_WRITE : OP_READ;
            addr_d = in_dcache_mem_addr;
            if (in_dcache_mem_write_en) begin
              wdata_d = in_dcache_mem_write_data;
            end
          end else begin
            op_d   = OP_READ;
            addr_d = in_icache_mem_addr;
          end
        end
      end

      BUSY: begin
        // in_mem_ready only has meaning here; elsewhere it is ignored.
        if (in_mem_ready) begin
          state_d = RESP;
          if (op_q == OP_READ) begin
            if (owner_q == PORT_D) begin
              drdata_d = in_mem_read_data;
            end else begin
              irdata_d = in_mem_read_data;
            end
          end
        end
      end

      RESP: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= PORT_I;
      op_q         <= OP_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= PORT_I;
      irdata_q     <= '0;
      drdata_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
      irdata_q     <= irdata_d;
      drdata_q     <= drdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Enables and ready pulses decode directly from the state register, so an
  // asynchronous reset removes them immediately without waiting for a clock.
  always_comb begin
    out_mem_read_en      = (state_q == BUSY) && (op_q == OP_READ);
    out_mem_write_en     = (state_q == BUSY) && (op_q == OP_WRITE);
    out_icache_mem_ready = (state_q == RESP) && (owner_q == PORT_I);
    out_dcache_mem_ready = (state_q == RESP) && (owner_q == PORT_D);
  end

  assign out_mem_addr             = addr_q;
  assign out_mem_write_data       = wdata_q;
  assign out_icache_mem_read_data = irdata_q;
  assign out_dcache_mem_read_data = drdata_q;
  assign out_grant_dcache         = owner_q;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int CL = 128;
  localparam int AW = 32;

  logic          clk;
  logic          reset;
  logic          in_icache_mem_read_en;
  logic [AW-1:0] in_icache_mem_addr;
  logic          out_icache_mem_ready;
  logic [CL-1:0] out_icache_mem_read_data;
  logic          in_dcache_mem_read_en;
  logic          in_dcache_mem_write_en;
  logic [AW-1:0] in_dcache_mem_addr;
  logic [CL-1:0] in_dcache_mem_write_data;
  logic          out_dcache_mem_ready;
  logic [CL-1:0] out_dcache_mem_read_data;
  logic          out_mem_read_en;
  logic          out_mem_write_en;
  logic [AW-1:0] out_mem_addr;
  logic [CL-1:0] out_mem_write_data;
  logic          in_mem_ready;
  logic [CL-1:0] in_mem_read_data;
  logic          out_grant_dcache;

  mem_arbiter #(.CACHE_LINE_SIZE(CL), .ADDR_W(AW)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .in_icache_mem_read_en    (in_icache_mem_read_en),
    .in_icache_mem_addr       (in_icache_mem_addr),
    .out_icache_mem_ready     (out_icache_mem_ready),
    .out_icache_mem_read_data (out_icache_mem_read_data),
    .in_dcache_mem_read_en    (in_dcache_mem_read_en),
    .in_dcache_mem_write_en   (in_dcache_mem_write_en),
    .in_dcache_mem_addr       (in_dcache_mem_addr),
    .in_dcache_mem_write_data (in_dcache_mem_write_data),
    .out_dcache_mem_ready     (out_dcache_mem_ready),
    .out_dcache_mem_read_data (out_dcache_mem_read_data),
    .out_mem_read_en          (out_mem_read_en),
    .out_mem_write_en         (out_mem_write_en),
    .out_mem_addr             (out_mem_addr),
    .out_mem_write_data       (out_mem_write_data),
    .in_mem_ready             (in_mem_ready),
    .in_mem_read_data         (in_mem_read_data),
    .out_grant_dcache         (out_grant_dcache)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          port;
    logic          wr;
    logic [AW-1:0] addr;
    logic [CL-1:0] wdata;
  } txn_t;

  txn_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [CL-1:0] exp_rd_i = '0;
  logic [CL-1:0] exp_rd_d = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic port, input logic wr, input logic [AW-1:0] addr,
                      input logic [CL-1:0] wdata);
    txn_t e;
    e.port = port; e.wr = wr; e.addr = addr; e.wdata = wdata;
    sb.push_back(e);
  endtask

  task automatic drop(input logic port);
    if (port == PORT_I) begin
      in_icache_mem_read_en = 1'b0;
    end else begin
      in_dcache_mem_read_en  = 1'b0;
      in_dcache_mem_write_en = 1'b0;
    end
  endtask

  // Acts as memory for one transaction and checks it against the scoreboard.
  // drop_mode: 0 keep request, 1 drop owner at ready, 2 drop owner right after
  // the command appears, 3 drop both ports at ready.
  task automatic serve(input int lat, input logic [CL-1:0] rdata, input int exp_wait,
                       input int drop_mode);
    txn_t e;
    int   n;
    n = 0;
    while (!(out_mem_read_en || out_mem_write_en) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_within_bound", 128'(n < 40), 128'(1));
    if (n >= 40) return;
    if (exp_wait >= 0) chk("cmd_latency", 128'(n), 128'(exp_wait));
    chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("grant_dcache", 128'(out_grant_dcache), 128'(e.port));
    chk("mem_read_en", 128'(out_mem_read_en), 128'(!e.wr));
    chk("mem_write_en", 128'(out_mem_write_en), 128'(e.wr));
    chk("mem_addr", 128'(out_mem_addr), 128'(e.addr));
    if (e.wr) chk("mem_wdata", out_mem_write_data, e.wdata);
    if (drop_mode == 2) drop(e.port);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      chk("cmd_held", 128'({out_mem_read_en, out_mem_write_en}), 128'({!e.wr, e.wr}));
      chk("addr_held", 128'(out_mem_addr), 128'(e.addr));
    end
    in_mem_ready     = 1'b1;
    in_mem_read_data = rdata;
    @(negedge clk);
    in_mem_ready     = 1'b0;
    in_mem_read_data = ~rdata;
    chk("en_dropped", 128'({out_mem_read_en, out_mem_write_en}), 128'(0));
    chk("icache_ready", 128'(out_icache_mem_ready), 128'(e.port == PORT_I));
    chk("dcache_ready", 128'(out_dcache_mem_ready), 128'(e.port == PORT_D));
    if (!e.wr) begin
      if (e.port == PORT_D) exp_rd_d = rdata;
      else                  exp_rd_i = rdata;
    end
    chk("icache_rdata", out_icache_mem_read_data, exp_rd_i);
    chk("dcache_rdata", out_dcache_mem_read_data, exp_rd_d);
    if (drop_mode == 1) drop(e.port);
    if (drop_mode == 3) begin
      drop(PORT_I);
      drop(PORT_D);
    end
    @(negedge clk);
    chk("ready_one_cycle", 128'({out_icache_mem_ready, out_dcache_mem_ready}), 128'(0));
    chk("idle_gap", 128'({out_mem_read_en, out_mem_write_en}), 128'(0));
    $display("TXN port=%s op=%s addr=%h lat=%0d", (e.port == PORT_D) ? "D" : "I",
             e.wr ? "WR" : "RD", e.addr, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CL-1:0] d_a5;
    logic [CL-1:0] d_wb;
    d_a5 = {16{8'hA5}};
    d_wb = 128'h00112233445566778899AABBCCDDEEFF;

    reset                    = 1'b1;
    in_icache_mem_read_en    = 1'b0;
    in_icache_mem_addr       = '0;
    in_dcache_mem_read_en    = 1'b0;
    in_dcache_mem_write_en   = 1'b0;
    in_dcache_mem_addr       = '0;
    in_dcache_mem_write_data = '0;
    in_mem_ready             = 1'b0;
    in_mem_read_data         = '0;

    // Reset state
    @(negedge clk);
    chk("rst_enables", 128'({out_mem_read_en, out_mem_write_en}), 128'(0));
    chk("rst_ready", 128'({out_icache_mem_ready, out_dcache_mem_ready}), 128'(0));
    chk("rst_addr", 128'(out_mem_addr), 128'(0));
    chk("rst_wdata", out_mem_write_data, '0);
    chk("rst_irdata", out_icache_mem_read_data, '0);
    chk("rst_drdata", out_dcache_mem_read_data, '0);
    chk("rst_grant", 128'(out_grant_dcache), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // I-cache read, memory ready after 3 cycles
    in_icache_mem_read_en = 1'b1;
    in_icache_mem_addr    = 32'h0000_1000;
    push(PORT_I, 1'b0, 32'h0000_1000, '0);
    serve(3, d_a5, 1, 1);

    // Simultaneous requests after reset-time last-grant: D first, then I
    in_icache_mem_read_en = 1'b1;
    in_icache_mem_addr    = 32'h0000_2000;
    in_dcache_mem_read_en = 1'b1;
    in_dcache_mem_addr    = 32'h0000_3000;
    push(PORT_D, 1'b0, 32'h0000_3000, '0);
    push(PORT_I, 1'b0, 32'h0000_2000, '0);
    serve(1, 128'h3333_0000_0000_0000_0000_0000_0000_D00D, 1, 1);
    serve(2, 128'h2222_0000_0000_0000_0000_0000_0000_1CAC, 1, 1);

    // D writeback with both enables set: write wins, read_data untouched
    in_dcache_mem_read_en    = 1'b1;
    in_dcache_mem_write_en   = 1'b1;
    in_dcache_mem_addr       = 32'h0000_4010;
    in_dcache_mem_write_data = d_wb;
    push(PORT_D, 1'b1, 32'h0000_4010, d_wb);
    serve(2, {16{8'h5A}}, 1, 1);

    // Reset one cycle into BUSY aborts the transaction
    in_icache_mem_read_en = 1'b1;
    in_icache_mem_addr    = 32'h0000_5500;
    push(PORT_I, 1'b0, 32'h0000_5500, '0);
    @(negedge clk);
    chk("pre_abort_busy", 128'(out_mem_read_en), 128'(1));
    reset = 1'b1;
    #1;
    chk("abort_en_async", 128'({out_mem_read_en, out_mem_write_en}), 128'(0));
    chk("abort_addr_async", 128'(out_mem_addr), 128'(0));
    exp_rd_i = '0;
    exp_rd_d = '0;
    chk("abort_irdata", out_icache_mem_read_data, exp_rd_i);
    @(negedge clk);
    chk("abort_no_ready", 128'({out_icache_mem_ready, out_dcache_mem_ready}), 128'(0));
    chk("abort_en_held", 128'({out_mem_read_en, out_mem_write_en}), 128'(0));
    void'(sb.pop_front());
    push(PORT_I, 1'b0, 32'h0000_5500, '0);
    reset = 1'b0;
    serve(1, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 1, 1);

    // in_mem_ready pulsed in IDLE is ignored
    @(negedge clk);
    in_mem_ready     = 1'b1;
    in_mem_read_data = {16{8'hEE}};
    @(negedge clk);
    in_mem_ready = 1'b0;
    chk("idle_ready_no_pulse", 128'({out_icache_mem_ready, out_dcache_mem_ready}), 128'(0));
    chk("idle_ready_no_cmd", 128'({out_mem_read_en, out_mem_write_en}), 128'(0));
    chk("idle_ready_irdata", out_icache_mem_read_data, exp_rd_i);
    @(negedge clk);
    chk("idle_ready_still_idle", 128'({out_icache_mem_ready, out_mem_read_en}), 128'(0));

    // Request withdrawn mid-BUSY still completes
    in_icache_mem_read_en = 1'b1;
    in_icache_mem_addr    = 32'h0000_7000;
    push(PORT_I, 1'b0, 32'h0000_7000, '0);
    serve(2, 128'h7777_0000_7777_0000_7777_0000_7777_0000, 1, 2);

    // Both held continuously: D,I,D,I,D,I
    in_icache_mem_read_en = 1'b1;
    in_icache_mem_addr    = 32'h0000_8000;
    in_dcache_mem_read_en = 1'b1;
    in_dcache_mem_addr    = 32'h0000_9000;
    for (int t = 0; t < 6; t++) begin
      if (t % 2 == 0) push(PORT_D, 1'b0, 32'h0000_9000, '0);
      else            push(PORT_I, 1'b0, 32'h0000_8000, '0);
    end
    for (int t = 0; t < 6; t++) begin
      logic [CL-1:0] rd;
      rd = {4{32'hC0DE_0000 + 32'(t)}};
      serve(1 + (t % 2), rd, 1, (t == 5) ? 3 : 0);
    end

    repeat (3) @(negedge clk);
    chk("final_idle", 128'({out_mem_read_en, out_mem_write_en}), 128'(0));
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter CACHE_LINE_SIZE, default 128, memory line width in bits.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 clk  input  1  single clock; all sequential logic on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_icache_mem_read_en  input  1  I-cache line-fill request, held until ready.
REQ-006 in_icache_mem_addr  input  ADDR_W  I-cache line address.
REQ-007 out_icache_mem_ready  output  1  one-cycle completion pulse to I-cache.
REQ-008 out_icache_mem_read_data  output  CACHE_LINE_SIZE  I-cache fill data.
REQ-009 in_dcache_mem_read_en  input  1  D-cache refill request, held until ready.
REQ-010 in_dcache_mem_write_en  input  1  D-cache writeback request, held until ready.
REQ-011 in_dcache_mem_addr  input  ADDR_W  D-cache line address.
REQ-012 in_dcache_mem_write_data  input  CACHE_LINE_SIZE  D-cache writeback line.
REQ-013 out_dcache_mem_ready  output  1  one-cycle completion pulse to D-cache.
REQ-014 out_dcache_mem_read_data  output  CACHE_LINE_SIZE  D-cache refill data.
REQ-015 out_mem_read_en / out_mem_write_en  output  1 each  memory command, held until in_mem_ready.
REQ-016 out_mem_addr  output  ADDR_W; out_mem_write_data  output  CACHE_LINE_SIZE.
REQ-017 in_mem_ready  input  1; in_mem_read_data  input  CACHE_LINE_SIZE  memory response.
REQ-018 out_grant_dcache  output  1  owner of current or last transaction (1 = D-cache).

Function
REQ-019 FSM states: IDLE, BUSY, RESP; the state register changes only on posedge clk or reset.
REQ-020 IDLE: the block SHALL sample the requests; no request keeps IDLE with all outputs idle.
REQ-021 Single requester in IDLE: grant it, latch addr, op and write data, go to BUSY.
REQ-022 Both requesting in IDLE: round-robin grant to the port not granted last; after reset, the D-cache wins the first tie.
REQ-023 D-cache asserting both read_en and write_en: the write SHALL take precedence.
REQ-024 BUSY: drive out_mem_*_en from the latched op and hold the latched addr/data stable until in_mem_ready; the memory command SHALL be asserted in the cycle after the IDLE grant edge.
REQ-025 in_mem_ready high in BUSY: drop the memory enables at that edge; for reads, register in_mem_read_data into the owner's read_data; go to RESP.
REQ-026 RESP: assert the owner's ready for exactly one cycle, update last-grant, return to IDLE; the non-owner's ready SHALL stay 0.
REQ-027 Each read_data output SHALL hold its value until that port's next read completion; writes SHALL NOT alter it.
REQ-028 Request deasserted mid-BUSY: the transaction SHALL complete and pulse ready regardless.
REQ-029 in_mem_ready outside BUSY SHALL be ignored.
REQ-030 Minimum latency, request-sampled edge N to ready: mem enable in cycle N+1; with in_mem_ready at edge N+1, ready is high in cycle N+2.
REQ-031 Back-to-back: a request held through RESP SHALL be regranted only from the following IDLE cycle.

Reset
REQ-032 Reset SHALL immediately force IDLE, all enables and ready pulses to 0, out_mem_addr/out_mem_write_data/read_data outputs to 0, last-grant to I-cache, and out_grant_dcache to 0.
REQ-033 Reset mid-BUSY SHALL abort the transaction with no ready pulse; after release, requests SHALL be re-arbitrated from IDLE.

Structure
REQ-034 Shared package mem_arb_pkg SHALL hold the FSM state enum, port-ID constants (PORT_I=0, PORT_D=1) and the CACHE_LINE_SIZE default.
REQ-035 The two-way round-robin pick SHALL be a combinational sub-module named mem_arb_rr (inputs: two requests and last-grant; output: winner).

Verification
REQ-036 I-cache only reads 0x0000_1000, memory ready after 3 cycles with data 0xA5...A5 -> mem_read_en held 3 cycles, addr 0x1000, icache ready pulses once, icache read_data = 0xA5...A5.
REQ-037 Both request in the same cycle after reset (I 0x2000, D read 0x3000) -> D served first, then I; I waits for D's RESP and is granted from the next IDLE.
REQ-038 D writeback 0x4010 with data 0x1122...FF -> mem_write_en=1, write_data matches, dcache ready pulses; dcache read_data unchanged.
REQ-039 Both requesters held continuously for 6 transactions -> grants alternate D,I,D,I,D,I; no port starves.
REQ-040 Reset asserted 1 cycle into BUSY -> enables drop in the same cycle without waiting for clk; no ready pulse; the request is re-granted after release.
REQ-041 in_mem_ready pulsed in IDLE with no request -> no state change, no ready pulse.
